bslab_dec: RTL

//  Receive-side counterpart of the bslab XNOR line encoder (encoder: next line = ~(line ^ din), line idles 1).

---
 rtl/bslab_pkg.sv | 14 +
 rtl/bslab_bitdec.sv | 27 ++
 rtl/bslab_dec.sv | 134 +++++++++++++
 3 files changed

// File: rtl/bslab_pkg.sv
// bslab line-code shared types and defaults.
// Used by the decoder RTL and the encoder model in the bench.
package bslab_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    DATA = 1'b1
  } bslab_state_t;

  localparam int         DEF_DATA_W   = 8;
  localparam int         DEF_SYNC_W   = 8;
  localparam logic [7:0] DEF_SYNC_PAT = 8'h7E;

endpackage

// File: rtl/bslab_bitdec.sv
// bslab bit recovery: XNOR of current and previous line symbol.
// Ports: clk, rst, en, line_in -> dec_bit, bit_vld (en-gated).
module bslab_bitdec (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic line_in,
  output logic dec_bit,
  output logic bit_vld
);

  logic line_prev;

  // An idle line rests at 1, so the first symbol
  // after en rises is decoded against that level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_prev <= 1'b1;
    end else begin
      line_prev <= en ? line_in : 1'b1;
    end
  end

  assign dec_bit = ~(line_in ^ line_prev);
  assign bit_vld = en;

endmodule

// File: rtl/bslab_dec.sv
// bslab decoder: sync hunt, LSB-first deserializer, valid/ready out.
// Ports: clk, rst, en, line_in, out_* handshake, overflow, abort, locked.
module bslab_dec
  import bslab_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                SYNC_W   = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_W'(DEF_SYNC_PAT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              line_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              overflow,
  output logic              abort,
  output logic              locked
);

  localparam int CNT_W =
    (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DATA_W - 1);

  logic dec_bit;
  logic bit_vld;

  bslab_bitdec u_bitdec (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .line_in (line_in),
    .dec_bit (dec_bit),
    .bit_vld (bit_vld)
  );

  bslab_state_t      state, state_nxt;
  logic [SYNC_W-1:0] sync_sr, sync_nxt, sync_sh;
  logic [DATA_W-1:0] data_sr, data_nxt, data_sh;
  logic [CNT_W-1:0]  bit_cnt, cnt_nxt;
  logic              first_word, first_nxt;
  logic              load;
  logic              abort_nxt;

  assign sync_sh = {dec_bit, sync_sr[SYNC_W-1:1]};
  assign data_sh = {dec_bit, data_sr[DATA_W-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      sync_sr    <= '0;
      data_sr    <= '0;
      bit_cnt    <= '0;
      first_word <= 1'b0;
    end else begin
      state      <= state_nxt;
      sync_sr    <= sync_nxt;
      data_sr    <= data_nxt;
      bit_cnt    <= cnt_nxt;
      first_word <= first_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sync_nxt  = sync_sr;
    data_nxt  = data_sr;
    cnt_nxt   = bit_cnt;
    first_nxt = first_word;
    load      = 1'b0;
    abort_nxt = 1'b0;
    unique case (state)
      HUNT: begin
        if (bit_vld) begin
          if (sync_sh == SYNC_PAT) begin
            state_nxt = DATA;
            sync_nxt  = '0;
            cnt_nxt   = '0;
            first_nxt = 1'b1;
          end else begin
            sync_nxt = sync_sh;
          end
        end
      end
      DATA: begin
        if (!bit_vld) begin
          // Partial word is discarded; only a
          // non-empty one is reported.
          state_nxt = HUNT;
          cnt_nxt   = '0;
          abort_nxt = (bit_cnt != '0);
        end else begin
          data_nxt = data_sh;
          if (bit_cnt == LAST) begin
            load      = 1'b1;
            cnt_nxt   = '0;
            first_nxt = 1'b0;
          end else begin
            cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
    endcase
  end

  // A load always wins over an accept: the
  // accepted word leaves as the new one arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      overflow  <= 1'b0;
      abort     <= 1'b0;
    end else begin
      overflow <= 1'b0;
      abort    <= abort_nxt;
      if (load) begin
        out_data  <= data_sh;
        out_sof   <= first_word;
        out_valid <= 1'b1;
        overflow  <= out_valid & ~out_ready;
      end else if (out_valid & out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign locked = (state == DATA);

endmodule
